fetch_logic: RTL and testbench

FETCH_LOGIC -- requirements
Module: fetch_logic

---
 rtl/fetch_logic.sv | 151 +++++++++++++++
 tb/tb_fetch_logic.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_logic.sv
// Instruction fetch front end: one memory request in flight, a one-entry hold buffer absorbs a response that lands during stall.
// Redirects flush the decoder output; a response still owed by memory after a redirect is drained and dropped.
module fetch_logic #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        jump_branch_enable
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        req_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_vld_q;
  logic        jbe_q;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_pc_q;

  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic [31:0] hold_inc;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign pc_inc    = pc_q + 32'd4;
  assign hold_inc  = hold_pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      inst_q      <= NOP_INST;
      inst_pc_q   <= RESET_PC;
      inst_vld_q  <= 1'b0;
      jbe_q       <= 1'b0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= RESET_PC;
    end else begin
      jbe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Memory is never asked anything here, so a stray ack is simply ignored.
          state_q <= FETCH;
          req_q   <= 1'b1;
          if (redirect_valid) begin
            pc_q   <= redir_tgt;
            addr_q <= redir_tgt;
            jbe_q  <= 1'b1;
          end else begin
            addr_q <= pc_q;
          end
        end

        FETCH: begin
          if (redirect_valid) begin
            inst_q     <= NOP_INST;
            inst_vld_q <= 1'b0;
            jbe_q      <= 1'b1;
            pc_q       <= redir_tgt;
            if (imem_ack) begin
              addr_q <= redir_tgt;
            end else begin
              state_q <= DRAIN;
            end
          end else if (imem_ack) begin
            if (stall) begin
              hold_inst_q <= imem_rdata;
              hold_pc_q   <= pc_q;
              req_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              inst_q     <= imem_rdata;
              inst_pc_q  <= pc_q;
              inst_vld_q <= 1'b1;
              pc_q       <= pc_inc;
              addr_q     <= pc_inc;
            end
          end else if (!stall) begin
            inst_q     <= NOP_INST;
            inst_vld_q <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            inst_q     <= NOP_INST;
            inst_vld_q <= 1'b0;
            jbe_q      <= 1'b1;
            pc_q       <= redir_tgt;
            addr_q     <= redir_tgt;
            req_q      <= 1'b1;
            state_q    <= FETCH;
          end else if (!stall) begin
            inst_q     <= hold_inst_q;
            inst_pc_q  <= hold_pc_q;
            inst_vld_q <= 1'b1;
            pc_q       <= hold_inc;
            addr_q     <= hold_inc;
            req_q      <= 1'b1;
            state_q    <= FETCH;
          end
        end

        DRAIN: begin
          // Old address stays on the bus until memory answers; pc_q holds the newest target.
          if (redirect_valid) begin
            jbe_q <= 1'b1;
            pc_q  <= redir_tgt;
            if (imem_ack) begin
              addr_q  <= redir_tgt;
              state_q <= FETCH;
            end
          end else if (imem_ack) begin
            addr_q  <= pc_q;
            state_q <= FETCH;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req           = req_q;
  assign imem_addr          = addr_q;
  assign instruction        = inst_q;
  assign inst_pc            = inst_pc_q;
  assign inst_valid         = inst_vld_q;
  assign jump_branch_enable = jbe_q;

endmodule

// File: tb/tb_fetch_logic.sv
// Bench for fetch_logic: directed scenarios then random traffic, every cycle compared against a transaction-level model.
module tb_fetch_logic;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        jump_branch_enable;

  fetch_logic #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_rdata         (imem_rdata),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .instruction        (instruction),
    .inst_pc            (inst_pc),
    .inst_valid         (inst_valid),
    .jump_branch_enable (jump_branch_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks what is owed by memory and what sits in the buffer,
  // rather than any state machine.
  logic [31:0] m_pc, m_addr, m_inst, m_ipc;
  bit          m_req, m_ivld, m_jbe, m_active, m_drop;
  logic [63:0] m_buf[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit ack, input logic [31:0] rd,
                       input bit st, input bit rv, input logic [31:0] rpc);
    logic [63:0] e;
    m_jbe = 1'b0;
    if (r) begin
      m_active = 1'b0; m_pc = RST_PC; m_addr = RST_PC; m_req = 1'b0;
      m_inst = NOP; m_ipc = RST_PC; m_ivld = 1'b0; m_drop = 1'b0;
      m_buf.delete();
    end else if (!m_active) begin
      m_active = 1'b1;
      if (rv) begin
        m_pc  = rpc & 32'hFFFF_FFFC;
        m_jbe = 1'b1;
      end
      m_req  = 1'b1;
      m_addr = m_pc;
    end else if (rv) begin
      m_jbe  = 1'b1;
      m_inst = NOP;
      m_ivld = 1'b0;
      m_buf.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      if (m_req && !ack) begin
        m_drop = 1'b1;
      end else begin
        m_drop = 1'b0;
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end else if (m_drop) begin
      if (ack) begin
        m_drop = 1'b0;
        m_addr = m_pc;
      end
    end else if (m_buf.size() != 0) begin
      if (!st) begin
        e      = m_buf.pop_front();
        m_inst = e[31:0];
        m_ipc  = e[63:32];
        m_ivld = 1'b1;
        m_pc   = e[63:32] + 32'd4;
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end else if (ack) begin
      if (st) begin
        m_buf.push_back({m_pc, rd});
        m_req = 1'b0;
      end else begin
        m_inst = rd;
        m_ipc  = m_pc;
        m_ivld = 1'b1;
        m_pc   = m_pc + 32'd4;
        m_addr = m_pc;
      end
    end else if (!st) begin
      m_inst = NOP;
      m_ivld = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit ack, input bit st, input bit rv, input logic [31:0] rpc);
    reset          = r;
    imem_ack       = ack;
    imem_rdata     = ack ? memw(imem_addr) : 32'hDEAD_BEEF;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model(r, ack, imem_rdata, st, rv, rpc);
    #1;
    chk("req", 32'(imem_req), 32'(m_req));
    if (m_req || r) chk("addr", imem_addr, m_addr);
    chk("inst", instruction, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("inst_valid", 32'(inst_valid), 32'(m_ivld));
    chk("jbe", 32'(jump_branch_enable), 32'(m_jbe));
  endtask

  initial begin
    bit          r, rv, st, ak;
    logic [31:0] rp;
    logic [31:0] exp_a;

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Reset values
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_inst", instruction, NOP);
    chk("rst_req", 32'(imem_req), 32'd0);

    // IDLE -> FETCH
    step(0, 0, 0, 0, 0);
    chk("first_addr", imem_addr, RST_PC);

    // Back-to-back acks
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0);
      exp_a = 32'(4 * (i + 1));
      chk("seq_addr", imem_addr, exp_a);
      exp_a = 32'(4 * i);
      chk("seq_ipc", inst_pc, exp_a);
      chk("seq_vld", 32'(inst_valid), 32'd1);
    end

    // Ack at 8 while stalled for three cycles
    step(0, 1, 1, 0, 0);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_ipc", inst_pc, 32'd4);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("stall_req3", 32'(imem_req), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("hold_inst", instruction, memw(32'd8));
    chk("hold_ipc", inst_pc, 32'd8);
    chk("hold_next", imem_addr, 32'd12);

    // Redirect while request to 0x10 pending, ack two cycles late
    step(0, 1, 0, 0, 0);
    chk("pre_redir_addr", imem_addr, 32'h10);
    step(0, 0, 0, 1, 32'h0000_0103);
    chk("drain_jbe", 32'(jump_branch_enable), 32'd1);
    chk("drain_addr", imem_addr, 32'h10);
    step(0, 0, 0, 0, 0);
    chk("drain_jbe_once", 32'(jump_branch_enable), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("drop_vld", 32'(inst_valid), 32'd0);
    chk("drop_inst", instruction, NOP);
    chk("drain_target", imem_addr, 32'h100);
    step(0, 1, 0, 0, 0);
    chk("tgt_inst", instruction, memw(32'h100));

    // Redirect coincident with stall and ack
    step(0, 1, 1, 1, 32'h0000_0200);
    chk("rs_vld", 32'(inst_valid), 32'd0);
    chk("rs_inst", instruction, 32'h0000_0013);
    chk("rs_addr", imem_addr, 32'h200);
    step(0, 1, 0, 0, 0);
    chk("rs_tgt_ipc", inst_pc, 32'h200);

    // Wrap at the top of the address space
    step(0, 1, 0, 1, 32'hFFFF_FFFE);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);

    // Back-to-back redirects in DRAIN, then reset mid-DRAIN with a stale ack
    step(0, 0, 0, 1, 32'h0000_0300);
    step(0, 0, 0, 1, 32'h0000_0400);
    chk("b2b_jbe", 32'(jump_branch_enable), 32'd1);
    step(1, 0, 0, 0, 0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, RST_PC);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("stale_vld", 32'(inst_valid), 32'd0);
    chk("post_rst_addr", imem_addr, RST_PC);
    step(0, 1, 0, 0, 0);
    chk("post_rst_inst", instruction, memw(RST_PC));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      ak = imem_req && ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else rp = $urandom;
      step(r, ak, st, rv, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
